// File: rtl/charge_pkg.sv
// Package: charge_pkg
// Shared definitions for the charge session sequencer and the charge controller:
// session state encodings, money/time widths and the time saturation helper.
package charge_pkg;

    localparam int unsigned MONEY_W = 5;
    localparam int unsigned TIME_W  = 6;
    localparam logic [TIME_W-1:0] TIME_MAX = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INPUT  = 3'd1,
        ST_CHARGE = 3'd2,
        ST_DONE   = 3'd3
    } state_e;

    // Clamp an 11-bit time product/sum to the displayable range.
    function automatic logic [TIME_W-1:0] sat_time(input logic [10:0] v);
        return (v > 11'(TIME_MAX)) ? TIME_MAX : v[TIME_W-1:0];
    endfunction

endpackage

// File: rtl/charge_tick_gen.sv
// Module: charge_tick_gen
// Time-unit prescaler. Counts TICK_DIV clock cycles while enabled and flags the last
// cycle of each period; restart_i realigns the period to the next edge.
// Ports:
//   clk_i      system clock
//   rst_i      synchronous reset, active-high
//   restart_i  synchronous restart: counter back to 0 on the next edge
//   enable_i   count enable; when low the counter is held at 0 and no tick is produced
//   tick_o     high for one cycle at the end of every TICK_DIV-cycle period
module charge_tick_gen #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || restart_i || !enable_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Decoded from the register only, so the consumer may feed restart_i back
    // from logic that depends on tick_o without forming a loop.
    assign tick_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/charge_session_sequencer.sv
// Module: charge_session_sequencer
// Sequences one coin-paid charging session: IDLE -> INPUT (money entry) -> CHARGE
// (countdown at one unit per tick, relay on) -> DONE (hold) -> IDLE.
// Optional feature macro: TOPUP_EN -- when defined, a valid confirm during CHARGE adds
// money_in*MIN_PER_UNIT to the remaining time (saturating); invalid money pulses reject.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           arms a session from IDLE
//   press           keypad activity, restarts the INPUT idle timeout
//   clear           clears entry in INPUT, aborts the session in CHARGE
//   confirm         commits money_in
//   money_in        money total from the charge controller
//   session_state   0 IDLE, 1 INPUT, 2 CHARGE, 3 DONE
//   remaining_time  time units left
//   charge_en       relay enable (CHARGE only)
//   no_display      display blank (IDLE only)
//   reject          one-cycle pulse: confirm refused
//   timeout         one-cycle pulse: INPUT idle timeout fired
module charge_session_sequencer
    import charge_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned MIN_PER_UNIT = 2,
    parameter int unsigned MAX_MONEY    = 20,
    parameter int unsigned IDLE_TIMEOUT = 10,
    parameter int unsigned DONE_HOLD    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               press,
    input  logic               clear,
    input  logic               confirm,
    input  logic [MONEY_W-1:0] money_in,
    output logic [2:0]         session_state,
    output logic [TIME_W-1:0]  remaining_time,
    output logic               charge_en,
    output logic               no_display,
    output logic               reject,
    output logic               timeout
);

    localparam int unsigned HOLD_MAX = (IDLE_TIMEOUT > DONE_HOLD) ? IDLE_TIMEOUT : DONE_HOLD;
    localparam int unsigned HW       = $clog2(HOLD_MAX + 1);

    state_e            state_q, state_d;
    logic [TIME_W-1:0] rem_q, rem_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              reject_q, reject_d;
    logic              timeout_q, timeout_d;
    logic              charge_en_q, no_display_q;
    logic              tick, tick_en, restart;
    logic              money_ok;
    logic [10:0]       grant;

    assign grant    = 11'(money_in) * 11'(MIN_PER_UNIT);
    assign money_ok = (money_in != '0) && (32'(money_in) <= MAX_MONEY);
    assign tick_en  = (state_q != ST_IDLE);
    assign restart  = (state_d != state_q);

    charge_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i     (clk),
        .rst_i     (rst),
        .restart_i (restart),
        .enable_i  (tick_en),
        .tick_o    (tick)
    );

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        hold_d    = hold_q;
        reject_d  = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_INPUT;
            end
            ST_INPUT: begin
                if (clear) begin
                    hold_d = '0;
                end else if (confirm) begin
                    if (money_ok) begin
                        state_d = ST_CHARGE;
                        rem_d   = sat_time(grant);
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (tick) begin
                    if (hold_q == HW'(IDLE_TIMEOUT - 1)) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end else if (press) begin
                    hold_d = '0;
                end
            end
            ST_CHARGE: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
`ifdef TOPUP_EN
                end else if (confirm) begin
                    // Top-up keeps the divider phase; the tick of this cycle is consumed.
                    if (money_ok) begin
                        rem_d = sat_time(11'(rem_q) + grant);
                    end else begin
                        reject_d = 1'b1;
                    end
`endif
                end else if (tick) begin
                    if (rem_q <= TIME_W'(1)) begin
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        rem_d = rem_q - TIME_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (tick) begin
                    if (hold_q == HW'(DONE_HOLD - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase

        // The shared idle/hold counter is reloaded on every state entry.
        if (state_d != state_q) hold_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            hold_q       <= '0;
            reject_q     <= 1'b0;
            timeout_q    <= 1'b0;
            charge_en_q  <= 1'b0;
            no_display_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            hold_q       <= hold_d;
            reject_q     <= reject_d;
            timeout_q    <= timeout_d;
            charge_en_q  <= (state_d == ST_CHARGE);
            no_display_q <= (state_d == ST_IDLE);
        end
    end

    assign session_state  = state_q;
    assign remaining_time = rem_q;
    assign charge_en      = charge_en_q;
    assign no_display     = no_display_q;
    assign reject         = reject_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_charge_session_sequencer.sv
// Testbench for charge_session_sequencer (TICK_DIV=10, other parameters default).
// A per-cycle reference model pushes the expected registered outputs into a queue;
// a monitor pops and compares one entry after every clock edge.
module tb_charge_session_sequencer;

    localparam int TICK_DIV     = 10;
    localparam int MIN_PER_UNIT = 2;
    localparam int MAX_MONEY    = 20;
    localparam int IDLE_TIMEOUT = 10;
    localparam int DONE_HOLD    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, press = 1'b0, clear = 1'b0, confirm = 1'b0;
    logic [4:0] money_in = '0;
    logic [2:0] session_state;
    logic [5:0] remaining_time;
    logic       charge_en, no_display, reject, timeout;

    charge_session_sequencer #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .press          (press),
        .clear          (clear),
        .confirm        (confirm),
        .money_in       (money_in),
        .session_state  (session_state),
        .remaining_time (remaining_time),
        .charge_en      (charge_en),
        .no_display     (no_display),
        .reject         (reject),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int rem;
        bit ce;
        bit nd;
        bit rej;
        bit to;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: state as an int, ticks derived from cycles spent in the state.
    int m_state = 0, m_rem = 0, m_cyc = 0, m_ticks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic bit money_valid(input int m);
        return (m >= 1) && (m <= MAX_MONEY);
    endfunction

    task automatic model_step(input bit r, input bit s, input bit p, input bit c,
                              input bit cf, input int m);
        exp_t e;
        bit   tick;
        int   nst;
        e.rej = 0;
        e.to  = 0;
        if (r) begin
            m_state = 0; m_rem = 0; m_cyc = 0; m_ticks = 0;
        end else begin
            tick = (m_state != 0) && ((m_cyc % TICK_DIV) == TICK_DIV - 1);
            nst  = m_state;
            case (m_state)
                0: if (s) nst = 1;
                1: begin
                    if (c) m_ticks = 0;
                    else if (cf) begin
                        if (money_valid(m)) begin
                            nst   = 2;
                            m_rem = (m * MIN_PER_UNIT > 63) ? 63 : m * MIN_PER_UNIT;
                        end else e.rej = 1;
                    end else if (tick) begin
                        m_ticks++;
                        if (m_ticks == IDLE_TIMEOUT) begin
                            nst  = 0;
                            e.to = 1;
                        end
                    end else if (p) m_ticks = 0;
                end
                2: begin
                    if (c) begin
                        nst   = 0;
                        m_rem = 0;
`ifdef TOPUP_EN
                    end else if (cf) begin
                        if (money_valid(m)) begin
                            m_rem = m_rem + m * MIN_PER_UNIT;
                            if (m_rem > 63) m_rem = 63;
                        end else e.rej = 1;
`endif
                    end else if (tick) begin
                        m_rem--;
                        if (m_rem == 0) nst = 3;
                    end
                end
                3: if (tick) begin
                    m_ticks++;
                    if (m_ticks == DONE_HOLD) nst = 0;
                end
                default: nst = 0;
            endcase
            if (nst != m_state) begin
                m_cyc   = 0;
                m_ticks = 0;
            end else if (m_state != 0) begin
                m_cyc++;
            end
            m_state = nst;
        end
        e.st  = m_state;
        e.rem = m_rem;
        e.ce  = (m_state == 2);
        e.nd  = (m_state == 0);
        exp_q.push_back(e);
    endtask

    // Inputs change on the falling edge; the expectation for the next rising edge is queued.
    task automatic drive(input bit r, input bit s, input bit p, input bit c, input bit cf,
                         input logic [4:0] m);
        @(negedge clk);
        rst = r; start = s; press = p; clear = c; confirm = cf; money_in = m;
        model_step(r, s, p, c, cf, int'(m));
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 5'd0);
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state",      32'(session_state),  32'(e.st));
            chk("remaining",  32'(remaining_time), 32'(e.rem));
            chk("charge_en",  32'(charge_en),      32'(e.ce));
            chk("no_display", 32'(no_display),     32'(e.nd));
            chk("reject",     32'(reject),         32'(e.rej));
            chk("timeout",    32'(timeout),        32'(e.to));
        end
    end

    initial begin
        int wait_cyc;
        // 1: reset held while every input toggles
        for (int i = 0; i < 12; i++)
            drive(1, 1'(i), 1'(i >> 1), 1'(i >> 2), 1'(~i), 5'(i + 3));
        idle_n(1);
        chk("rst_state", 32'(session_state), 0);
        chk("rst_nodisp", 32'(no_display), 1);

        // 2: money 5 -> 10 units, DONE at 100 cycles after entry, IDLE 30 later
        drive(0, 1, 0, 0, 0, 5'd0);
        drive(0, 0, 0, 0, 1, 5'd5);
        idle_n(1);
        chk("t2_rem_entry", 32'(remaining_time), 10);
        chk("t2_ce_entry", 32'(charge_en), 1);
        idle_n(99);
        chk("t2_state_99", 32'(session_state), 2);
        chk("t2_rem_99", 32'(remaining_time), 1);
        idle_n(1);
        chk("t2_state_100", 32'(session_state), 3);
        chk("t2_ce_100", 32'(charge_en), 0);
        idle_n(29);
        chk("t2_done_129", 32'(session_state), 3);
        idle_n(1);
        chk("t2_idle_130", 32'(session_state), 0);

        // 3: rejects for 0 and 21, accept 20
        drive(0, 1, 0, 0, 0, 5'd0);
        drive(0, 0, 0, 0, 1, 5'd0);
        idle_n(1);
        chk("t3_rej0", 32'(reject), 1);
        drive(0, 0, 0, 0, 1, 5'd21);
        idle_n(1);
        chk("t3_rej21", 32'(reject), 1);
        chk("t3_state", 32'(session_state), 1);
        drive(0, 0, 0, 0, 1, 5'd20);
        idle_n(1);
        chk("t3_rem40", 32'(remaining_time), 40);

        // 6: confirm during CHARGE
        idle_n(2);
        drive(0, 0, 0, 0, 1, 5'd5);
        idle_n(1);
`ifdef TOPUP_EN
        chk("t6_topup", 32'(remaining_time), 50);
`else
        chk("t6_no_topup", 32'(remaining_time), 40);
`endif
        chk("t6_no_reject", 32'(reject), 0);
        drive(1, 0, 0, 0, 0, 5'd0);

        // 4: idle timeout, then press at cycle 95 postpones it
        drive(0, 1, 0, 0, 0, 5'd0);
        idle_n(100);
        chk("t4_input_99", 32'(session_state), 1);
        idle_n(1);
        chk("t4_idle_100", 32'(session_state), 0);
        chk("t4_timeout", 32'(timeout), 1);
        drive(0, 1, 0, 0, 0, 5'd0);
        idle_n(94);
        drive(0, 0, 1, 0, 0, 5'd0);
        idle_n(95);
        chk("t4_press_190", 32'(session_state), 1);
        idle_n(1);
        chk("t4_press_191", 32'(session_state), 0);

        // 5: abort from CHARGE with remaining 7, clear beats confirm
        drive(0, 1, 0, 0, 0, 5'd0);
        drive(0, 0, 0, 0, 1, 5'd4);
        idle_n(11);
        chk("t5_rem7", 32'(remaining_time), 7);
        drive(0, 0, 0, 1, 1, 5'd5);
        idle_n(1);
        chk("t5_state", 32'(session_state), 0);
        chk("t5_rem", 32'(remaining_time), 0);
        chk("t5_ce", 32'(charge_en), 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [4:0] m;
            m = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(1, 20)) : 5'($urandom);
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 11) == 0), m);
        end
        idle_n(1);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
